// File: rtl/aes_core_seq.sv
// Initiator-side sequencer for the AES core: one core_start per accepted block, single-entry result buffer.
// Optional watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_core_seq #(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              core_start,
    input  logic              core_ready,
    input  logic              core_done,
    output logic [DATA_W-1:0] core_din,
    input  logic [DATA_W-1:0] core_dout,
    output logic              busy,
    output logic              prot_err,
    output logic              timeout,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [DATA_W-1:0] r_coreDin;
    logic              r_protErr;
    logic              w_inReady;
    logic              w_accept;
    logic              w_capture;
    logic              w_timeoutHit;
    logic              w_coreStart;
    logic              w_busy;

    // Accept only when the result slot is empty or being drained this same cycle.
    assign w_inReady = reset_n & (r_state == S_IDLE) & core_ready & (~r_outValid | out_ready);
    assign w_accept  = in_valid & w_inReady;
    assign w_capture = (r_state == S_CAPT) & core_ready;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] r_wdCnt;
    logic             r_timeout;
    logic             w_expire;

    assign w_expire     = ((r_state == S_WAIT) | (r_state == S_CAPT)) &
                          (r_wdCnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_timeoutHit = w_expire & (((r_state == S_WAIT) & ~core_done) |
                                      ((r_state == S_CAPT) & ~core_ready));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wdCnt <= '0;
        end else if (r_state == S_START) begin
            r_wdCnt <= '0;
        end else if ((r_state == S_WAIT) || (r_state == S_CAPT)) begin
            r_wdCnt <= r_wdCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timeout <= 1'b0;
        end else if (w_timeoutHit) begin
            r_timeout <= 1'b1;
        end else if (err_clr) begin
            r_timeout <= 1'b0;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_timeoutHit = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_START;
            S_START: w_nextState = S_WAIT;
            S_WAIT: begin
                if (core_done)         w_nextState = S_CAPT;
                else if (w_timeoutHit) w_nextState = S_IDLE;
            end
            S_CAPT: begin
                if (core_ready)        w_nextState = S_IDLE;
                else if (w_timeoutHit) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_coreStart = (r_state == S_START);
        w_busy      = (r_state != S_IDLE);
    end

    // A capture in the drain cycle wins: new data loads and out_valid stays high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_coreDin  <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_coreDin <= in_data;
            end
            if (w_capture) begin
                r_outData  <= core_dout;
                r_outValid <= 1'b1;
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_protErr <= 1'b0;
        end else if (core_done && ((r_state == S_IDLE) || (r_state == S_START))) begin
            r_protErr <= 1'b1;
        end else if (err_clr) begin
            r_protErr <= 1'b0;
        end
    end

    assign in_ready   = w_inReady;
    assign out_valid  = r_outValid;
    assign out_data   = r_outData;
    assign core_din   = r_coreDin;
    assign core_start = w_coreStart;
    assign busy       = w_busy;
    assign prot_err   = r_protErr;

endmodule
